settle_detector: RTL and testbench
==================================

Name: settle_detector

Overview:
Downstream monitor for a first-order filter state output, carried as a fixed-point real (signed code, value = code * 2^EXP). After a start pulse it checks each valid sample against a constant target and tolerance. It declares the signal settled once HOLD consecutive samples fall in band, and declares a timeout if TIMEOUT samples pass without settling. Bench and system logic use settled, timeout and settle_cycles to gate the next test phase and to report settling time.

Parameters:
WIDTH, 18, bit width of the signed fixed-point input code
EXP, -14, binary exponent of the input format (informational; all arithmetic is on raw codes)
TARGET, 16384, signed target code (1.0 at EXP=-14)
TOL, 164, unsigned tolerance code (~0.01 at EXP=-14); a sample is in band when |in_val - TARGET| <= TOL
HOLD, 4, consecutive in-band samples required to settle; legal range 1..TIMEOUT
TIMEOUT, 64, maximum number of valid samples before timeout; legal range HOLD..65535

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; clears counters and begins tracking
in_val  input  WIDTH  signed fixed-point sample
in_valid  input  1  in_val is a new sample this cycle
busy  output  1  high while in TRACK
settled  output  1  high in SETTLED
timeout  output  1  high in TIMEOUT
settle_cycles  output  16  number of valid samples consumed since start
err_abs  output  WIDTH+1  registered |in_val - TARGET| of the last valid sample

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; busy, settled, timeout = 0; settle_cycles = 0; err_abs = 0; hold_cnt = 0.
- Error arithmetic: diff = sign-extend(in_val) - TARGET, computed in WIDTH+1 signed bits. abs_err = |diff|, held as WIDTH+1 unsigned. No overflow is possible. in_band = (abs_err <= TOL), combinational from the current in_val.
- States: IDLE, TRACK, SETTLED, TIMEOUT. All outputs are registered and decoded from state and counters.
- IDLE: samples are ignored. start -> TRACK; clear hold_cnt and settle_cycles.
- TRACK, on an in_valid cycle:
  - settle_cycles += 1.
  - err_abs <= abs_err.
  - hold_cnt = in_band ? hold_cnt+1 : 0.
  - If the new hold_cnt == HOLD -> SETTLED.
  - Else if the new settle_cycles == TIMEOUT -> TIMEOUT.
- TRACK, in_valid=0: all counters and err_abs are frozen; state is unchanged.
- Latency: settled rises on the clock edge that captures the HOLD-th consecutive in-band sample, i.e. visible in the cycle after that sample is presented. Same rule for timeout.
- Simultaneous HOLD-reached and TIMEOUT-reached on one sample: SETTLED wins.
- SETTLED and TIMEOUT are terminal. They hold their outputs, settle_cycles and err_abs until start or rst. Samples arriving in these states are ignored.
- start in any state, including TRACK/SETTLED/TIMEOUT: restart. State <- TRACK, counters <- 0, settled/timeout <- 0. A sample on the same cycle as start is discarded and not counted.
- rst asserted mid-operation: immediate return to reset values; start is ignored while rst=1.
- settle_cycles cannot exceed TIMEOUT, so no wrap is possible.
- Elaboration check: $error if HOLD < 1, TIMEOUT < HOLD, TIMEOUT > 65535, or TOL < 0.

Test Plan:
1. Defaults; start; feed one valid sample per cycle of the first-order response to 1.0 with blend factor 0.3: y_n = round((1-0.7^n)*16384), n=1.. (4915, 8356, 10764, ...). Sample 13 (code 16225, err 159) is the first in band -> settled rises after sample 16; settle_cycles=16; err_abs<=164; busy=0.
2. Constant in_val=0 with valid every cycle -> timeout after sample 64; settle_cycles=64; err_abs=16384; settled=0.
3. In-band run broken at its 3rd sample by 16549 (err 165, 1 LSB outside band), then 4 codes of 16384 -> settled after the 7th sample; settle_cycles=7.
4. HOLD=64, TIMEOUT=64, all samples 16384 -> sample 64 satisfies both conditions -> settled=1, timeout=0.
5. in_valid toggled 1/0 every cycle, in-band data -> settled only after the 4th valid sample (7 cycles after the first); counters frozen on gap cycles.
6. start asserted mid-TRACK together with in_valid, and rst pulsed asynchronously between edges -> counters clear, the coincident sample is not counted, and outputs drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/settle_detector_if.sv
// Sample/status bundle between a filter-output source and the settle detector.
// The master drives samples and start; the slave reports tracking status.
interface settle_detector_if #(
  parameter int WIDTH = 18
);
  logic                    start;
  logic signed [WIDTH-1:0] in_val;
  logic                    in_valid;
  logic                    busy;
  logic                    settled;
  logic                    timeout;
  logic [15:0]             settle_cycles;
  logic [WIDTH:0]          err_abs;

  modport master (
    output start, in_val, in_valid,
    input  busy, settled, timeout, settle_cycles, err_abs
  );

  modport slave (
    input  start, in_val, in_valid,
    output busy, settled, timeout, settle_cycles, err_abs
  );
endinterface

// File: rtl/settle_detector.sv
// Watches a fixed-point filter output after a start pulse and reports whether it
// settles within TOL of TARGET for HOLD consecutive samples before TIMEOUT samples.
module settle_detector #(
  parameter int WIDTH   = 18,
  parameter int EXP     = -14,
  parameter int TARGET  = 16384,
  parameter int TOL     = 164,
  parameter int HOLD    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  settle_detector_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_SETTLED = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam logic signed [WIDTH:0] C_TARGET  = (WIDTH+1)'(TARGET);
  localparam logic        [WIDTH:0] C_TOL     = (WIDTH+1)'(TOL);
  localparam logic        [15:0]    C_HOLD    = 16'(HOLD);
  localparam logic        [15:0]    C_TIMEOUT = 16'(TIMEOUT);

  generate
    if (HOLD < 1 || TIMEOUT < HOLD || TIMEOUT > 65535 || TOL < 0) begin : g_bad_params
      $error("settle_detector: illegal HOLD/TIMEOUT/TOL combination (EXP=%0d)", EXP);
    end
  endgenerate

  state_t                  r_state;
  state_t                  w_state_next;
  logic [15:0]             r_hold_cnt;
  logic [15:0]             r_settle_cycles;
  logic [WIDTH:0]          r_err_abs;

  logic signed [WIDTH:0]   w_diff;
  logic        [WIDTH:0]   w_abs_err;
  logic                    w_in_band;
  logic                    w_accept;
  logic [15:0]             w_hold_next;
  logic [15:0]             w_cycles_next;

  // One extra bit of headroom makes the subtraction and its negation overflow-free.
  assign w_diff        = $signed({bus.in_val[WIDTH-1], bus.in_val}) - C_TARGET;
  assign w_abs_err     = w_diff[WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_in_band     = (w_abs_err <= C_TOL);
  assign w_accept      = (r_state == S_TRACK) && bus.in_valid;
  assign w_hold_next   = w_in_band ? (r_hold_cnt + 16'd1) : 16'd0;
  assign w_cycles_next = r_settle_cycles + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Start overrides everything; a settle on the final allowed sample beats timeout.
  always_comb begin
    w_state_next = r_state;
    if (bus.start) begin
      w_state_next = S_TRACK;
    end else if (w_accept) begin
      if (w_hold_next == C_HOLD) begin
        w_state_next = S_SETTLED;
      end else if (w_cycles_next == C_TIMEOUT) begin
        w_state_next = S_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt      <= '0;
      r_settle_cycles <= '0;
      r_err_abs       <= '0;
    end else if (bus.start) begin
      r_hold_cnt      <= '0;
      r_settle_cycles <= '0;
    end else if (w_accept) begin
      r_hold_cnt      <= w_hold_next;
      r_settle_cycles <= w_cycles_next;
      r_err_abs       <= w_abs_err;
    end
  end

  always_comb begin
    bus.busy          = (r_state == S_TRACK);
    bus.settled       = (r_state == S_SETTLED);
    bus.timeout       = (r_state == S_TIMEOUT);
    bus.settle_cycles = r_settle_cycles;
    bus.err_abs       = r_err_abs;
  end

endmodule

// File: tb/tb_settle_detector.sv
// Directed plus randomized bench for settle_detector; two instances (default and
// HOLD=TIMEOUT=64) are checked against a sample-history reference model.
module tb_settle_detector;

  localparam int WIDTH  = 18;
  localparam int TARGET = 16384;
  localparam int TOL    = 164;

  logic clk;
  logic rst;

  settle_detector_if #(.WIDTH(WIDTH)) ifa ();
  settle_detector_if #(.WIDTH(WIDTH)) ifb ();

  settle_detector #(
    .WIDTH(WIDTH), .EXP(-14), .TARGET(TARGET), .TOL(TOL), .HOLD(4), .TIMEOUT(64)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  settle_detector #(
    .WIDTH(WIDTH), .EXP(-14), .TARGET(TARGET), .TOL(TOL), .HOLD(64), .TIMEOUT(64)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;
  int step_no;

  // Reference model: remembers every accepted sample's error since start and
  // judges settling from the trailing in-band run length.
  int m_hold [0:1];
  int m_tout [0:1];
  bit m_act  [0:1];
  bit m_set  [0:1];
  bit m_tmo  [0:1];
  int m_cnt  [0:1];
  int m_err  [0:1];
  int m_hist [0:1][0:63];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0;
      m_set[k] = 1'b0;
      m_tmo[k] = 1'b0;
      m_cnt[k] = 0;
      m_err[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit st, input bit vld, input int val);
    int e;
    int run;
    if (st) begin
      m_act[k] = 1'b1;
      m_set[k] = 1'b0;
      m_tmo[k] = 1'b0;
      m_cnt[k] = 0;
    end else if (m_act[k] && vld) begin
      e = val - TARGET;
      if (e < 0) e = -e;
      m_hist[k][m_cnt[k]] = e;
      m_cnt[k] = m_cnt[k] + 1;
      m_err[k] = e;
      run = 0;
      for (int i = m_cnt[k] - 1; i >= 0; i--) begin
        if (m_hist[k][i] > TOL) break;
        run++;
      end
      if (run >= m_hold[k]) begin
        m_set[k] = 1'b1;
        m_act[k] = 1'b0;
      end else if (m_cnt[k] == m_tout[k]) begin
        m_tmo[k] = 1'b1;
        m_act[k] = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0d expected %0d (step %0d)", tag, got, exp, step_no);
    end
  endtask

  task automatic check_all();
    check("a_busy",    64'(ifa.busy),          64'(m_act[0]));
    check("a_settled", 64'(ifa.settled),       64'(m_set[0]));
    check("a_timeout", 64'(ifa.timeout),       64'(m_tmo[0]));
    check("a_cycles",  64'(ifa.settle_cycles), 64'(m_cnt[0]));
    check("a_err",     64'(ifa.err_abs),       64'(m_err[0]));
    check("b_busy",    64'(ifb.busy),          64'(m_act[1]));
    check("b_settled", 64'(ifb.settled),       64'(m_set[1]));
    check("b_timeout", 64'(ifb.timeout),       64'(m_tmo[1]));
    check("b_cycles",  64'(ifb.settle_cycles), 64'(m_cnt[1]));
    check("b_err",     64'(ifb.err_abs),       64'(m_err[1]));
  endtask

  task automatic drive(input bit st, input bit vld, input int val);
    ifa.start    = st;
    ifb.start    = st;
    ifa.in_valid = vld;
    ifb.in_valid = vld;
    ifa.in_val   = WIDTH'(val);
    ifb.in_val   = WIDTH'(val);
  endtask

  task automatic step(input bit st, input bit vld, input int val);
    @(negedge clk);
    drive(st, vld, val);
    @(posedge clk);
    model_edge(0, st, vld, val);
    model_edge(1, st, vld, val);
    #1;
    step_no++;
    check_all();
    $display("step %0d st=%0b v=%0b x=%0d | A b%0b s%0b t%0b n=%0d e=%0d | B b%0b s%0b t%0b n=%0d e=%0d",
             step_no, st, vld, val,
             ifa.busy, ifa.settled, ifa.timeout, ifa.settle_cycles, ifa.err_abs,
             ifb.busy, ifb.settled, ifb.timeout, ifb.settle_cycles, ifb.err_abs);
  endtask

  initial begin
    int y;
    bit st;
    bit vld;
    int val;

    n_vec   = 0;
    n_miss  = 0;
    step_no = 0;
    m_hold[0] = 4;  m_tout[0] = 64;
    m_hold[1] = 64; m_tout[1] = 64;
    model_reset();

    // Reset state
    rst = 1'b1;
    drive(1'b0, 1'b0, 0);
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // 1: first-order step response, blend 0.3
    step(1'b1, 1'b0, 0);
    for (int n = 1; n <= 20; n++) begin
      y = $rtoi((1.0 - (0.7 ** n)) * 16384.0 + 0.5);
      step(1'b0, 1'b1, y);
      if (n == 15) check("t1_not_yet", 64'(ifa.settled), 64'd0);
    end
    check("t1_settled", 64'(ifa.settled), 64'd1);
    check("t1_cycles",  64'(ifa.settle_cycles), 64'd16);
    check("t1_err_band", 64'(ifa.err_abs <= 19'(TOL)), 64'd1);
    check("t1_busy",    64'(ifa.busy), 64'd0);

    // 2: stuck at zero -> timeout
    step(1'b1, 1'b0, 0);
    for (int n = 0; n < 70; n++) step(1'b0, 1'b1, 0);
    check("t2_timeout", 64'(ifa.timeout), 64'd1);
    check("t2_settled", 64'(ifa.settled), 64'd0);
    check("t2_cycles",  64'(ifa.settle_cycles), 64'd64);
    check("t2_err",     64'(ifa.err_abs), 64'd16384);

    // 3: in-band run broken one LSB outside tolerance
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 16384);
    step(1'b0, 1'b1, 16384);
    step(1'b0, 1'b1, 16549);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 16384);
    check("t3_not_yet", 64'(ifa.settled), 64'd0);
    step(1'b0, 1'b1, 16384);
    check("t3_settled", 64'(ifa.settled), 64'd1);
    check("t3_cycles",  64'(ifa.settle_cycles), 64'd7);

    // 4: HOLD == TIMEOUT, settle wins on the last sample
    step(1'b1, 1'b0, 0);
    for (int n = 0; n < 64; n++) step(1'b0, 1'b1, 16384);
    check("t4_settled", 64'(ifb.settled), 64'd1);
    check("t4_timeout", 64'(ifb.timeout), 64'd0);
    check("t4_cycles",  64'(ifb.settle_cycles), 64'd64);

    // 5: valid every other cycle
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i % 2) == 0, 16384 + i);
      if (i == 5) begin
        check("t5_gap_cycles",  64'(ifa.settle_cycles), 64'd3);
        check("t5_gap_settled", 64'(ifa.settled), 64'd0);
      end
      if (i == 6) check("t5_settled", 64'(ifa.settled), 64'd1);
    end

    // 6: restart mid-track with a coincident sample, then async reset
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 16000);
    step(1'b0, 1'b1, 16384);
    step(1'b1, 1'b1, 16384);
    check("t6_restart_cycles", 64'(ifa.settle_cycles), 64'd0);
    step(1'b0, 1'b1, 16300);
    check("t6_after_cycles", 64'(ifa.settle_cycles), 64'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check("t6_async_cycles", 64'(ifa.settle_cycles), 64'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 16384);
    @(posedge clk);
    #1;
    check_all();
    check("t6_start_in_rst", 64'(ifa.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 16384);

    // Randomized phase: values straddling the tolerance band, sparse valid and restarts
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 300; i++) begin
      st  = ($urandom_range(0, 39) == 0);
      vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) val = int'($urandom_range(0, 60000)) - 30000;
      else                           val = TARGET + int'($urandom_range(0, 440)) - 220;
      step(st, vld, val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
